// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: FSM state encoding and the hard-wired zero register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

    // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source operands of the instruction in ID.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller turns load_use_o into a stall.
//
// Ports:
//   ex_mem_read_i  instruction in EX is a load
//   ex_rd_i        destination register of the instruction in EX
//   id_rs1_i       rs1 of the instruction in ID
//   id_rs2_i       rs2 of the instruction in ID
//   load_use_o     ID needs a value the EX load has not produced yet
module hazard_detect
    import pipe_pkg::*;
(
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs1_i,
    input  logic [4:0] id_rs2_i,
    output logic       load_use_o
);

    always_comb begin
        load_use_o = ex_mem_read_i
                   & (ex_rd_i != REG_X0)
                   & ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: PC / IF/ID / ID/EX / MEM/WB enables, flushes and bubbles, memory watchdog.
// Latency: controls are combinational from state and inputs; state, watchdog, error flag and counter update on clk_i.
// Backpressure: an unacknowledged data-memory access freezes the pipeline; a load-use hazard stalls IF/ID and bubbles ID/EX.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               leave IDLE (sampled only in IDLE)
//   ID_rs1_i, ID_rs2_i    source registers of the instruction in ID
//   EX_MemRead_i, EX_rd_i load flag and destination of the instruction in EX
//   branch_taken_i        branch in ID resolved taken
//   MEM_access_i          instruction in MEM performs a load or store
//   mem_ack_i             data memory completes the current access
//   mem_req_o .. memwb_bubble_o   pipeline register / PC controls
//   err_o                 sticky memory-timeout flag
//   stall_cnt_o           saturating count of frozen or load-use-stalled cycles
module pipeline_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       ID_rs1_i,
    input  logic [4:0]       ID_rs2_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_rd_i,
    input  logic             branch_taken_i,
    input  logic             MEM_access_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_freeze_o,
    output logic             memwb_bubble_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam logic [15:0]      TMO_LIMIT = 16'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_e           state_q, state_d;
    logic [15:0]      tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic in_run;
    logic in_wait;
    logic freeze;

    hazard_detect u_hazard_detect (
        .ex_mem_read_i (EX_MemRead_i),
        .ex_rd_i       (EX_rd_i),
        .id_rs1_i      (ID_rs1_i),
        .id_rs2_i      (ID_rs2_i),
        .load_use_o    (load_use)
    );

    // Control outputs. IDLE and ERROR fall into the freeze branch, so the
    // load-use and branch branches only ever act in RUN / MEM_WAIT.
    always_comb begin
        in_run  = (state_q == ST_RUN);
        in_wait = (state_q == ST_MEM_WAIT);
        // A mem_ack_i outside RUN-with-access / MEM_WAIT has no effect here,
        // because it only ever qualifies terms that already require a request.
        freeze  = (in_run & MEM_access_i & ~mem_ack_i)
                | (in_wait & ~mem_ack_i)
                | (state_q == ST_IDLE)
                | (state_q == ST_ERROR);

        mem_req_o      = (in_run & MEM_access_i) | in_wait;
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        pipe_freeze_o  = 1'b0;
        memwb_bubble_o = 1'b0;

        if (freeze) begin
            // MEM/WB takes a bubble so the instruction already in WB retires once.
            pipe_freeze_o  = 1'b1;
            memwb_bubble_o = 1'b1;
        end else if (load_use) begin
            // No flush here: a taken branch in ID must wait for its operand.
            idex_bubble_o = 1'b1;
        end else if (branch_taken_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            ifid_flush_o = 1'b1;
        end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
        end
    end

    // Next-state, watchdog, error flag and stall counter.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        stall_cnt_d = stall_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Ack in the same cycle as the access is a zero-wait access.
                if (MEM_access_i && !mem_ack_i) begin
                    state_d = ST_MEM_WAIT;
                    tmo_d   = 16'd1;
                end
            end
            ST_MEM_WAIT: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (mem_ack_i) begin
                    state_d = ST_RUN;
                    tmo_d   = 16'd0;
                end else if (tmo_q == TMO_LIMIT) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if ((in_run || in_wait) && (freeze || load_use) && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            tmo_q       <= 16'd0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign err_o       = err_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: single-cycle RUN vectors from a table, then memory-wait sequences.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 4;

    // Output bundle order: {req, pc_write, ifid_write, ifid_flush, idex_bubble, freeze, memwb_bubble}
    localparam logic [6:0] O_NORM   = 7'b0110000;
    localparam logic [6:0] O_STALL  = 7'b0000100;
    localparam logic [6:0] O_BRANCH = 7'b0111000;
    localparam logic [6:0] O_RNORM  = 7'b1110000;
    localparam logic [6:0] O_RSTALL = 7'b1000100;
    localparam logic [6:0] O_RBR    = 7'b1111000;
    localparam logic [6:0] O_FRZ    = 7'b0000011;
    localparam logic [6:0] O_RFRZ   = 7'b1000011;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             start_i;
    logic [4:0]       ID_rs1_i, ID_rs2_i, EX_rd_i;
    logic             EX_MemRead_i, branch_taken_i, MEM_access_i, mem_ack_i;
    logic             mem_req_o, pc_write_o, ifid_write_o, ifid_flush_o;
    logic             idex_bubble_o, pipe_freeze_o, memwb_bubble_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       mrd;
        logic       br;
        logic       acc;
        logic       ack;
        logic [6:0] exp;
        logic       inc;
    } vec_t;

    vec_t vecs [13];

    always #5 clk_i = ~clk_i;

    pipeline_hazard_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .ID_rs1_i       (ID_rs1_i),
        .ID_rs2_i       (ID_rs2_i),
        .EX_MemRead_i   (EX_MemRead_i),
        .EX_rd_i        (EX_rd_i),
        .branch_taken_i (branch_taken_i),
        .MEM_access_i   (MEM_access_i),
        .mem_ack_i      (mem_ack_i),
        .mem_req_o      (mem_req_o),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .pipe_freeze_o  (pipe_freeze_o),
        .memwb_bubble_o (memwb_bubble_o),
        .err_o          (err_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    function automatic logic [6:0] outs();
        return {mem_req_o, pc_write_o, ifid_write_o, ifid_flush_o,
                idex_bubble_o, pipe_freeze_o, memwb_bubble_o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Model of the saturating stall counter.
    task automatic bump(input int n);
        for (int i = 0; i < n; i++) begin
            if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
        end
    endtask

    task automatic idle_inputs();
        ID_rs1_i = 5'd0; ID_rs2_i = 5'd0; EX_rd_i = 5'd0;
        EX_MemRead_i = 1'b0; branch_taken_i = 1'b0;
        MEM_access_i = 1'b0; mem_ack_i = 1'b0;
    endtask

    initial begin
        //            rs1    rs2    rd     mrd   br    acc   ack   exp       inc
        vecs[0]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, O_NORM,   1'b0};
        vecs[1]  = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_STALL,  1'b1};
        vecs[2]  = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, O_NORM,   1'b0};
        vecs[3]  = '{5'd1,  5'd7,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, O_STALL,  1'b1};
        vecs[4]  = '{5'd7,  5'd0,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0, O_NORM,   1'b0};
        vecs[5]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, O_BRANCH, 1'b0};
        vecs[6]  = '{5'd2,  5'd3,  5'd3,  1'b1, 1'b1, 1'b0, 1'b0, O_STALL,  1'b1};
        vecs[7]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b1, O_RNORM,  1'b0};
        vecs[8]  = '{5'd9,  5'd0,  5'd9,  1'b1, 1'b0, 1'b1, 1'b1, O_RSTALL, 1'b1};
        vecs[9]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b1, 1'b1, O_RBR,    1'b0};
        vecs[10] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, O_NORM,   1'b0};
        vecs[11] = '{5'd6,  5'd4,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, O_NORM,   1'b0};
        vecs[12] = '{5'd0,  5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, O_STALL,  1'b1};

        // Reset state
        rst_i = 1'b1; start_i = 1'b0; idle_inputs();
        #1;
        chk("reset_outs", 32'(outs()), 32'(O_FRZ));
        chk("reset_cnt", 32'(stall_cnt_o), 0);
        chk("reset_err", 32'(err_o), 0);
        tick();
        rst_i = 1'b0;

        // IDLE: load-use inputs present but nothing counts or moves
        EX_MemRead_i = 1'b1; EX_rd_i = 5'd5; ID_rs1_i = 5'd5;
        tick(); tick();
        chk("idle_outs", 32'(outs()), 32'(O_FRZ));
        chk("idle_cnt", 32'(stall_cnt_o), 0);
        idle_inputs();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;

        // Single-cycle vectors in RUN
        for (int i = 0; i < 13; i++) begin
            ID_rs1_i = vecs[i].rs1; ID_rs2_i = vecs[i].rs2; EX_rd_i = vecs[i].rd;
            EX_MemRead_i = vecs[i].mrd; branch_taken_i = vecs[i].br;
            MEM_access_i = vecs[i].acc; mem_ack_i = vecs[i].ack;
            #4;
            chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp));
            tick();
            if (vecs[i].inc) bump(1);
            chk($sformatf("vec%0d_cnt", i), 32'(stall_cnt_o), 32'(exp_cnt));
        end

        // Multi-cycle access: ack arrives three cycles after the request
        idle_inputs();
        MEM_access_i = 1'b1;
        #4; chk("mw_run_outs", 32'(outs()), 32'(O_RFRZ));
        tick(); #3; chk("mw_wait1_outs", 32'(outs()), 32'(O_RFRZ));
        tick(); #3; chk("mw_wait2_outs", 32'(outs()), 32'(O_RFRZ));
        tick(); mem_ack_i = 1'b1;
        #3; chk("mw_ack_outs", 32'(outs()), 32'(O_RNORM));
        tick(); idle_inputs();
        bump(3);
        #3; chk("mw_back_run", 32'(outs()), 32'(O_NORM));
        chk("mw_cnt", 32'(stall_cnt_o), 32'(exp_cnt));

        // Ack on the very last allowed MEM_WAIT cycle beats the timeout
        MEM_access_i = 1'b1;
        for (int c = 1; c <= int'(TIMEOUT); c++) begin
            tick();
            if (c == int'(TIMEOUT)) mem_ack_i = 1'b1;
        end
        #3; chk("edge_ack_outs", 32'(outs()), 32'(O_RNORM));
        tick(); idle_inputs();
        bump(TIMEOUT);
        #3; chk("edge_back_run", 32'(outs()), 32'(O_NORM));
        chk("edge_err", 32'(err_o), 0);
        chk("edge_cnt", 32'(stall_cnt_o), 32'(exp_cnt));

        // Timeout: never ack; counter saturates along the way
        MEM_access_i = 1'b1;
        for (int c = 1; c <= int'(TIMEOUT); c++) tick();
        bump(TIMEOUT);
        #3; chk("tmo_last_wait_outs", 32'(outs()), 32'(O_RFRZ));
        chk("tmo_last_wait_err", 32'(err_o), 0);
        chk("tmo_sat_cnt", 32'(stall_cnt_o), 32'(exp_cnt));
        tick();
        bump(1);
        #3; chk("err_outs", 32'(outs()), 32'(O_FRZ));
        chk("err_flag", 32'(err_o), 1);
        chk("err_cnt_sat", 32'(stall_cnt_o), 32'((1 << CNT_W) - 1));
        idle_inputs();
        start_i = 1'b1; mem_ack_i = 1'b1;
        tick(); tick();
        start_i = 1'b0; mem_ack_i = 1'b0;
        #3; chk("err_sticky_outs", 32'(outs()), 32'(O_FRZ));
        chk("err_sticky_flag", 32'(err_o), 1);

        // Async reset in the middle of a MEM_WAIT cycle
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        exp_cnt = 0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        MEM_access_i = 1'b1;
        tick();
        bump(1);
        #2; chk("ar_wait_req", 32'(mem_req_o), 1);
        chk("ar_wait_cnt", 32'(stall_cnt_o), 32'(exp_cnt));
        rst_i = 1'b1;
        #1;
        chk("ar_outs", 32'(outs()), 32'(O_FRZ));
        chk("ar_cnt", 32'(stall_cnt_o), 0);
        chk("ar_err", 32'(err_o), 0);
        tick();
        rst_i = 1'b0; mem_ack_i = 1'b1;
        tick(); tick();
        chk("ar_idle_outs", 32'(outs()), 32'(O_FRZ));
        chk("ar_idle_cnt", 32'(stall_cnt_o), 0);
        idle_inputs();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        #3; chk("ar_restart_outs", 32'(outs()), 32'(O_NORM));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
